// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and fetch state encoding for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  localparam int unsigned IFS_ADDR_WIDTH = 5;
  localparam int unsigned IFS_DATA_WIDTH = 32;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] IFS_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_memory.sv
// Instruction storage: one synchronous write port for program load and one
// combinational read port addressed by the PC. Contents are never reset.
module instruction_memory #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Program-load write; deliberately no reset so a reset keeps the program.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read of the word under the current PC.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: serves the PC from instruction memory, owns the
// IF/ID pipeline register and the LOAD/RUN/HALT fetch FSM, and produces the
// PC write enable covering stall, flush and halt.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IFS_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = IFS_DATA_WIDTH,
  parameter int unsigned           DEPTH      = 2 ** ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(IFS_HALT_WORD)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_enable,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  write_pc,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0] out_instruction_address,
  output logic                  out_valid,
  output logic                  halted
);

  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(NOP_WORD);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  valid_q;
  logic                  halted_q;

  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  fetch_is_halt;
  logic                  mem_we;

  // Memory only accepts writes while the program is being loaded.
  always_comb begin
    mem_we        = load_enable && (state_q == StLoad);
    fetch_is_halt = (fetch_word == HALT_WORD);
  end

  instruction_memory #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_imem (
    .clk_i  (clock),
    .we_i   (mem_we),
    .waddr_i(load_address),
    .wdata_i(load_data),
    .raddr_i(instruction_address),
    .rdata_o(fetch_word)
  );

  // Fetch FSM and IF/ID register; flush beats stall, a HALT word is latched once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StLoad;
      instr_q  <= Nop;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          instr_q <= Nop;
          valid_q <= 1'b0;
          if (load_done) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (flush) begin
            instr_q <= Nop;
            valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q <= fetch_word;
            addr_q  <= instruction_address;
            valid_q <= 1'b1;
            if (fetch_is_halt) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
          end
        end
        StHalt: begin
          // Issue bubbles; a flush means the halt was on a wrong path.
          instr_q <= Nop;
          valid_q <= 1'b0;
          if (flush) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

  // PC write enable: flush always lets the branch target in; never step past HALT.
  always_comb begin
    write_pc = (state_q != StLoad) &&
               (flush || ((state_q == StRun) && !stall && !fetch_is_halt));
  end

  assign out_instruction         = instr_q;
  assign out_instruction_address = addr_q;
  assign out_valid               = valid_q;
  assign halted                  = halted_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage.
module tb_instruction_fetch_stage;

  logic        clock;
  logic        reset;
  logic        load_enable;
  logic [4:0]  load_address;
  logic [31:0] load_data;
  logic        load_done;
  logic [4:0]  instruction_address;
  logic        stall;
  logic        flush;
  logic        write_pc;
  logic [31:0] out_instruction;
  logic [4:0]  out_instruction_address;
  logic        out_valid;
  logic        halted;

  int n_cmp;
  int n_err;

  instruction_fetch_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .load_enable            (load_enable),
    .load_address           (load_address),
    .load_data              (load_data),
    .load_done              (load_done),
    .instruction_address    (instruction_address),
    .stall                  (stall),
    .flush                  (flush),
    .write_pc               (write_pc),
    .out_instruction        (out_instruction),
    .out_instruction_address(out_instruction_address),
    .out_valid              (out_valid),
    .halted                 (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_enable = 1'b0; load_address = '0; load_data = '0;
    load_done = 1'b0; instruction_address = '0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_instruction !== 32'h0) begin
      n_err++; $display("FAIL reset_instr: got %h want 00000000", out_instruction);
    end
    n_cmp++;
    if (out_instruction_address !== 5'd0) begin
      n_err++; $display("FAIL reset_addr: got %0d want 0", out_instruction_address);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || halted !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got valid=%b halted=%b want 0/0", out_valid, halted);
    end
    n_cmp++;
    if (write_pc !== 1'b0) begin
      n_err++; $display("FAIL reset_wpc: got %b want 0", write_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] prog [6];
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33;
    prog[3] = 32'h44; prog[4] = 32'h55; prog[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      load_enable = 1'b1; load_address = 5'(i); load_data = prog[i];
      instruction_address = 5'(i);
      flush = (i == 2);           // must be ignored while loading
      load_done = (i == 5);       // write and done on the same edge
      #1;
      n_cmp++;
      if (write_pc !== 1'b0) begin
        n_err++; $display("FAIL load_wpc[%0d]: got %b want 0", i, write_pc);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin
        n_err++;
        $display("FAIL load_ifid[%0d]: got valid=%b instr=%h want 0/00000000",
                 i, out_valid, out_instruction);
      end
    end
    load_enable = 1'b0; load_done = 1'b0; flush = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] exp [2];
    exp[0] = 32'h11; exp[1] = 32'h22;
    for (int i = 0; i < 2; i++) begin
      instruction_address = 5'(i);
      #1;
      n_cmp++;
      if (write_pc !== 1'b1) begin
        n_err++; $display("FAIL fetch_wpc[%0d]: got %b want 1", i, write_pc);
      end
      tick();
      n_cmp++;
      if (out_instruction !== exp[i] || out_instruction_address !== 5'(i) ||
          out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fetch_ifid[%0d]: got %h/%0d/%b want %h/%0d/1", i, out_instruction,
                 out_instruction_address, out_valid, exp[i], i);
      end
    end
  endtask

  task automatic test_stall();
    instruction_address = 5'd2; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (write_pc !== 1'b0) begin
        n_err++; $display("FAIL stall_wpc[%0d]: got %b want 0", i, write_pc);
      end
      tick();
      n_cmp++;
      if (out_instruction !== 32'h22 || out_instruction_address !== 5'd1 ||
          out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h/%0d/%b want 00000022/1/1", i, out_instruction,
                 out_instruction_address, out_valid);
      end
    end
    stall = 1'b0;
    #1;
    n_cmp++;
    if (write_pc !== 1'b1) begin
      n_err++; $display("FAIL stall_release_wpc: got %b want 1", write_pc);
    end
    tick();
    n_cmp++;
    if (out_instruction !== 32'h33 || out_instruction_address !== 5'd2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got %h/%0d/%b want 00000033/2/1", out_instruction,
               out_instruction_address, out_valid);
    end
  endtask

  task automatic test_flush_over_stall();
    instruction_address = 5'd3; stall = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (write_pc !== 1'b1) begin
      n_err++; $display("FAIL flush_stall_wpc: got %b want 1", write_pc);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin
      n_err++;
      $display("FAIL flush_stall_ifid: got valid=%b instr=%h want 0/00000000",
               out_valid, out_instruction);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_halt();
    instruction_address = 5'd4;
    tick();
    n_cmp++;
    if (out_instruction !== 32'h55 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_halt: got %h/%b want 00000055/1", out_instruction, out_valid);
    end
    instruction_address = 5'd5;
    #1;
    n_cmp++;
    if (write_pc !== 1'b0) begin
      n_err++; $display("FAIL halt_wpc: got %b want 0", write_pc);
    end
    tick();
    n_cmp++;
    if (out_instruction !== 32'hFFFF_FFFF || out_instruction_address !== 5'd5 ||
        out_valid !== 1'b1 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_latch: got %h/%0d/v%b/h%b want ffffffff/5/v1/h1", out_instruction,
               out_instruction_address, out_valid, halted);
    end
    n_cmp++;
    if (write_pc !== 1'b0) begin
      n_err++; $display("FAIL halt_state_wpc: got %b want 0", write_pc);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_instruction !== 32'h0 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_bubble: got v%b/%h/h%b want v0/00000000/h1", out_valid,
               out_instruction, halted);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (write_pc !== 1'b1) begin
      n_err++; $display("FAIL halt_flush_wpc: got %b want 1", write_pc);
    end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (halted !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_flush: got h%b/v%b want h0/v0", halted, out_valid);
    end
    instruction_address = 5'd0;
    tick();
    n_cmp++;
    if (out_instruction !== 32'h11 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL halt_resume: got %h/%b want 00000011/1", out_instruction, out_valid);
    end
  endtask

  task automatic test_async_reset();
    instruction_address = 5'd5;
    tick();
    n_cmp++;
    if (halted !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL areset_setup: got h%b/v%b want h1/v1", halted, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || out_instruction !== 32'h0) begin
      n_err++;
      $display("FAIL areset_immediate: got h%b/v%b/%h want h0/v0/00000000", halted,
               out_valid, out_instruction);
    end
    #1;
    reset = 1'b0;
    instruction_address = 5'd0;
    #1;
    n_cmp++;
    if (write_pc !== 1'b0) begin
      n_err++; $display("FAIL areset_load_wpc: got %b want 0", write_pc);
    end
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    n_cmp++;
    if (out_instruction !== 32'h11 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset_refetch: got %h/%b want 00000011/1", out_instruction, out_valid);
    end
  endtask

  task automatic test_load_ignored_in_run();
    load_enable = 1'b1; load_address = 5'd0; load_data = 32'h99;
    instruction_address = 5'd1;
    tick();
    load_enable = 1'b0;
    n_cmp++;
    if (out_instruction !== 32'h22) begin
      n_err++; $display("FAIL run_load_side: got %h want 00000022", out_instruction);
    end
    instruction_address = 5'd0;
    tick();
    n_cmp++;
    if (out_instruction !== 32'h11 || out_instruction_address !== 5'd0) begin
      n_err++;
      $display("FAIL run_load_ignored: got %h/%0d want 00000011/0", out_instruction,
               out_instruction_address);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load();
    test_fetch();
    test_stall();
    test_flush_over_stall();
    test_halt();
    test_async_reset();
    test_load_ignored_in_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
